// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Parametrised pipeline-stage register for the 16-bit processor. Carries
// CHANNELS fields of WIDTH bits from one stage to the next, with a valid
// bit, stall (hold), flush (bubble insertion) and NOP substitution on the
// instruction channel (channel 0). Usable as IF/ID, ID/EX, EX/MEM or MEM/WB.
//
// Optional feature macro: PIPE_STAT_EN
//   When defined, adds the saturating statistics counters stall_cnt and
//   bubble_cnt. The datapath is identical with or without it.
//
// Parameters:
//   WIDTH    - bits per channel
//   CHANNELS - number of channels, channel 0 is the instruction channel
//   NOP_VAL  - value forced onto channel 0 whenever a bubble is loaded
//   CNT_W    - width of the statistics counters (PIPE_STAT_EN only)
//
// Ports:
//   clk        - clock, all state updates on its rising edge
//   rst        - synchronous active-high reset
//   valid_in   - upstream stage presents a real instruction
//   data_in    - packed channels, channel k is [k*WIDTH +: WIDTH]
//   stall      - hold current contents
//   flush      - discard current contents and load a bubble
//   data_out   - registered channels
//   valid_out  - data_out holds a real instruction
//   stall_cnt  - saturating count of stall-hold cycles (PIPE_STAT_EN)
//   bubble_cnt - saturating count of bubbles loaded (PIPE_STAT_EN)
//
// Edge action priority: rst > flush > stall > load.
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int               WIDTH    = 16,
    parameter int               CHANNELS = 2,
    parameter logic [WIDTH-1:0] NOP_VAL  = WIDTH'(16'h0800),
    parameter int               CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_in,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic                      stall,
    input  logic                      flush,
    output logic [CHANNELS*WIDTH-1:0] data_out,
`ifdef PIPE_STAT_EN
    output logic                      valid_out,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          bubble_cnt
`else
    output logic                      valid_out
`endif
);

    // Bubble pattern: NOP on channel 0, zero elsewhere (also the reset value).
    // Invalid-input pattern: NOP on channel 0, remaining channels pass
    // data_in through so downstream debug logic can still see them.
    logic [CHANNELS*WIDTH-1:0] bubble_pat;
    logic [CHANNELS*WIDTH-1:0] invalid_pat;

    assign bubble_pat[0 +: WIDTH]  = NOP_VAL;
    assign invalid_pat[0 +: WIDTH] = NOP_VAL;

    generate
        for (genvar gi = 1; gi < CHANNELS; gi++) begin : g_chan
            assign bubble_pat[gi*WIDTH +: WIDTH]  = '0;
            assign invalid_pat[gi*WIDTH +: WIDTH] = data_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    logic [CHANNELS*WIDTH-1:0] data_q;
    logic [CHANNELS*WIDTH-1:0] data_d;
    logic                      valid_q;
    logic                      valid_d;
    logic                      bubble_ev;   // a new bubble enters this edge
    logic                      stall_ev;    // the stage holds this edge

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        bubble_ev = 1'b0;
        stall_ev  = 1'b0;
        if (flush) begin
            // flush wins over stall; counted only as a bubble
            data_d    = bubble_pat;
            valid_d   = 1'b0;
            bubble_ev = 1'b1;
        end else if (stall) begin
            // holding an existing bubble is not a new bubble
            stall_ev  = 1'b1;
        end else if (valid_in) begin
            data_d    = data_in;
            valid_d   = 1'b1;
        end else begin
            data_d    = invalid_pat;
            valid_d   = 1'b0;
            bubble_ev = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= bubble_pat;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;

`ifdef PIPE_STAT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d;

    // Saturating increments: stick at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stall_ev && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (bubble_ev && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    // Without statistics the event flags have no consumer.
    logic unused_ev;
    assign unused_ev = bubble_ev ^ stall_ev;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed and randomized checks of pipe_stage_reg (WIDTH=16, CHANNELS=2).
// The reference model tracks the expected stage contents and counters
// directly from the edge-action rules (rst > flush > stall > load).
// Counters are instantiated 4 bits wide so saturation is reachable.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [31:0] data_in;
    logic        stall;
    logic        flush;
    logic [31:0] data_out;
    logic        valid_out;
`ifdef PIPE_STAT_EN
    logic [3:0]  stall_cnt;
    logic [3:0]  bubble_cnt;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [31:0] m_data;
    logic        m_valid;
    int          m_sc;
    int          m_bc;

    pipe_stage_reg #(
        .WIDTH    (16),
        .CHANNELS (2),
        .NOP_VAL  (16'h0800),
        .CNT_W    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .stall      (stall),
        .flush      (flush),
        .data_out   (data_out),
`ifdef PIPE_STAT_EN
        .valid_out  (valid_out),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`else
        .valid_out  (valid_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one edge worth of inputs, advance the model, compare after the edge.
    task automatic step(input string tag, input logic r, input logic f,
                        input logic s, input logic v, input logic [31:0] d);
        rst      = r;
        flush    = f;
        stall    = s;
        valid_in = v;
        data_in  = d;
        @(posedge clk);
        if (r) begin
            m_data = 32'h0000_0800; m_valid = 1'b0; m_sc = 0; m_bc = 0;
        end else if (f) begin
            m_data = 32'h0000_0800; m_valid = 1'b0;
            if (m_bc < 15) m_bc++;
        end else if (s) begin
            if (m_sc < 15) m_sc++;
        end else if (v) begin
            m_data = d; m_valid = 1'b1;
        end else begin
            m_data = {d[31:16], 16'h0800}; m_valid = 1'b0;
            if (m_bc < 15) m_bc++;
        end
        #1;
        $display("[TB] %s rst=%0b flush=%0b stall=%0b vin=%0b din=%h -> dout=%h vout=%0b",
                 tag, r, f, s, v, d, data_out, valid_out);
        chk({tag, "_data"}, data_out, m_data);
        chk({tag, "_valid"}, {31'd0, valid_out}, {31'd0, m_valid});
`ifdef PIPE_STAT_EN
        chk({tag, "_scnt"}, {28'd0, stall_cnt}, 32'(m_sc));
        chk({tag, "_bcnt"}, {28'd0, bubble_cnt}, 32'(m_bc));
`endif
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; stall = 1'b0; valid_in = 1'b0; data_in = '0;
        m_data = '0; m_valid = 1'b0; m_sc = 0; m_bc = 0;

        // Reset with live-looking input
        step("reset", 1, 0, 0, 1, 32'hDEAD_BEEF);
        chk("reset_lit", data_out, 32'h0000_0800);
        chk("reset_vout_lit", {31'd0, valid_out}, 32'd0);

        // Streaming
        step("stream0", 0, 0, 0, 1, 32'h0002_1234);
        chk("stream0_lit", data_out, 32'h0002_1234);
        step("stream1", 0, 0, 0, 1, 32'h0004_5678);
        chk("stream1_lit", data_out, 32'h0004_5678);

        // Stall hold for 3 cycles
        step("load", 0, 0, 0, 1, 32'h0002_1234);
        for (int i = 0; i < 3; i++) begin
            step("stall", 0, 0, 1, 1, 32'hFFFF_FFFF);
            chk("stall_hold_lit", data_out, 32'h0002_1234);
        end
`ifdef PIPE_STAT_EN
        chk("stall_cnt3_lit", {28'd0, stall_cnt}, 32'd3);
`endif
        step("resume", 0, 0, 0, 1, 32'hFFFF_FFFF);
        chk("resume_lit", data_out, 32'hFFFF_FFFF);

        // Flush beats stall
        step("flush_stall", 0, 1, 1, 1, 32'h1111_2222);
        chk("flush_lit", data_out, 32'h0000_0800);
`ifdef PIPE_STAT_EN
        chk("flush_bcnt_lit", {28'd0, bubble_cnt}, 32'd1);
        chk("flush_scnt_lit", {28'd0, stall_cnt}, 32'd3);
`endif

        // Stall on a bubble: held, not recounted
        step("stall_bubble", 0, 0, 1, 1, 32'h3333_4444);

        // Invalid input
        step("invalid", 0, 0, 0, 0, 32'h0006_ABCD);
        chk("invalid_lit", data_out, 32'h0006_0800);

        // Saturation: 20 stalls
        step("load2", 0, 0, 0, 1, 32'h0007_0001);
        for (int i = 0; i < 20; i++) begin
            step("sat_stall", 0, 0, 1, 0, 32'(i));
        end
`ifdef PIPE_STAT_EN
        chk("sat_lit", {28'd0, stall_cnt}, 32'h0000_000F);
`endif
        step("sat_rst", 1, 0, 1, 1, 32'h5555_5555);
`ifdef PIPE_STAT_EN
        chk("sat_rst_lit", {28'd0, stall_cnt}, 32'd0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
